// File: rtl/instr_queue_unit.sv
// Fetch-to-decode instruction FIFO with per-entry branch epoch tags.
// A head entry whose epoch differs from epoch_ref is shown as a NOP, or is silently drained when DROP_STALE=1.
module instr_queue_unit #(
  parameter int                 INSTR_W    = 32,
  parameter int                 DEPTH      = 4,
  parameter int                 EPOCH_W    = 1,
  parameter logic [INSTR_W-1:0] NOP        = INSTR_W'(32'hE320F000),
  parameter bit                 DROP_STALE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic [EPOCH_W-1:0]           epoch_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EPOCH_W-1:0]           epoch_ref,
  input  logic                         sel_stall,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [EPOCH_W-1:0]           out_epoch,
  output logic                         out_valid,
  output logic                         out_squash,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [EPOCH_W-1:0] mem_epoch [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  logic               empty, stale, pop, push;
  logic [INSTR_W-1:0] head_instr;
  logic [EPOCH_W-1:0] head_epoch;

  assign empty      = (count == '0);
  assign head_instr = mem_instr[rd_ptr];
  assign head_epoch = mem_epoch[rd_ptr];
  assign stale      = !empty && (head_epoch != epoch_ref);

  // In drop mode a stale head drains even while the decoder stalls.
  assign pop      = DROP_STALE ? (stale || (!empty && !sel_stall))
                               : (!empty && !sel_stall);
  assign in_ready = (count < CNT_W'(DEPTH)) || pop;
  assign push     = in_valid && in_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    out_instr  = NOP;
    out_epoch  = '0;
    out_valid  = 1'b0;
    out_squash = 1'b0;
    if (!empty) begin
      out_epoch = head_epoch;
      if (stale) begin
        out_squash = 1'b1;
        out_valid  = !DROP_STALE;
      end else begin
        out_instr = head_instr;
        out_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= instr_in;
      mem_epoch[wr_ptr] <= epoch_in;
    end
  end

endmodule

// File: tb/tb_instr_queue_unit.sv
// Randomised and directed bench for instr_queue_unit in both stale-handling modes.
// A queue-based model predicts every output each cycle.
module tb_instr_queue_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'hE320F000;

  typedef struct packed {
    logic [31:0] instr;
    logic        epoch;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, sel_stall;
  logic [31:0] instr_in;
  logic        epoch_in, epoch_ref;

  logic        in_ready0, out_valid0, out_squash0, out_epoch0;
  logic [31:0] out_instr0;
  logic [2:0]  count0;
  logic        in_ready1, out_valid1, out_squash1, out_epoch1;
  logic [31:0] out_instr1;
  logic [2:0]  count1;

  int vectors = 0;
  int miscompares = 0;

  ent_t q0[$];
  ent_t q1[$];

  always #5 clk = ~clk;

  instr_queue_unit #(.DEPTH(DEPTH), .DROP_STALE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .instr_in(instr_in), .epoch_in(epoch_in),
    .in_valid(in_valid), .in_ready(in_ready0), .epoch_ref(epoch_ref), .sel_stall(sel_stall),
    .out_instr(out_instr0), .out_epoch(out_epoch0), .out_valid(out_valid0),
    .out_squash(out_squash0), .count(count0)
  );

  instr_queue_unit #(.DEPTH(DEPTH), .DROP_STALE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .instr_in(instr_in), .epoch_in(epoch_in),
    .in_valid(in_valid), .in_ready(in_ready1), .epoch_ref(epoch_ref), .sel_stall(sel_stall),
    .out_instr(out_instr1), .out_epoch(out_epoch1), .out_valid(out_valid1),
    .out_squash(out_squash1), .count(count1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predicts one instance's outputs from its model queue and returns what it will do at the edge.
  task automatic check_inst(input string nm, input int n, input ent_t head, input bit drop,
                            input logic [31:0] oi, input logic oe, input logic ov, input logic os,
                            input logic [2:0] cnt, input logic rdy,
                            output bit do_pop, output bit do_push);
    bit          is_stale, e_rdy;
    logic [31:0] e_instr;
    logic        e_valid, e_squash, e_epoch;
    is_stale = (n != 0) && (head.epoch != epoch_ref);
    if (n == 0) begin
      e_instr = NOP_W; e_valid = 1'b0; e_squash = 1'b0; e_epoch = 1'b0;
    end else if (is_stale) begin
      e_instr = NOP_W; e_valid = !drop; e_squash = 1'b1; e_epoch = head.epoch;
    end else begin
      e_instr = head.instr; e_valid = 1'b1; e_squash = 1'b0; e_epoch = head.epoch;
    end
    do_pop  = drop ? (is_stale || (n != 0 && !sel_stall)) : (n != 0 && !sel_stall);
    e_rdy   = (n < DEPTH) || do_pop;
    do_push = in_valid && e_rdy;
    check({nm, ".out_instr"},  64'(oi),  64'(e_instr));
    check({nm, ".out_valid"},  64'(ov),  64'(e_valid));
    check({nm, ".out_squash"}, 64'(os),  64'(e_squash));
    check({nm, ".out_epoch"},  64'(oe),  64'(e_epoch));
    check({nm, ".count"},      64'(cnt), 64'(n));
    check({nm, ".in_ready"},   64'(rdy), 64'(e_rdy));
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                      input logic ep, input logic eref, input logic st);
    bit   pop0, push0, pop1, push1;
    ent_t h0, h1, e;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; instr_in = ins; epoch_in = ep;
    epoch_ref = eref; sel_stall = st;
    #1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    check_inst("m0", q0.size(), h0, 1'b0, out_instr0, out_epoch0, out_valid0, out_squash0,
               count0, in_ready0, pop0, push0);
    check_inst("m1", q1.size(), h1, 1'b1, out_instr1, out_epoch1, out_valid1, out_squash1,
               count1, in_ready1, pop1, push1);
    e.instr = ins;
    e.epoch = ep;
    @(posedge clk);
    if (r || f) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back(e);
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back(e);
    end
  endtask

  task automatic push_w(input logic [31:0] w, input logic ep, input logic eref, input logic st);
    step(1'b0, 1'b0, 1'b1, w, ep, eref, st);
  endtask

  task automatic idle(input logic eref, input logic st);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, eref, st);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr_in = '0; epoch_in = 1'b0;
    epoch_ref = 1'b0; sel_stall = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset.count", 64'(count0), 64'd0);
    check("reset.in_ready", 64'(in_ready0), 64'd1);
    check("reset.out_instr", 64'(out_instr0), 64'(NOP_W));
    check("reset.out_valid", 64'(out_valid1), 64'd0);

    // Fill with stall held, then drain.
    for (int i = 0; i < DEPTH; i++) push_w(32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    #2;
    check("fill.count", 64'(count0), 64'd4);
    check("fill.in_ready", 64'(in_ready0), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b0, 1'b0);
    #2;
    check("drain.out_valid", 64'(out_valid0), 64'd0);
    check("drain.out_instr", 64'(out_instr0), 64'(NOP_W));

    // Full queue with simultaneous push and pop across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) push_w(32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) push_w(32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    #2;
    check("fullpp.count", 64'(count0), 64'd4);
    check("fullpp.in_ready", 64'(in_ready0), 64'd1);

    // Stale head: NOP in present mode, discarded under stall in drop mode.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    push_w(32'hB000_0000, 1'b0, 1'b0, 1'b1);
    push_w(32'hB000_0001, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    #2;
    check("drop.count", 64'(count1), 64'd1);
    check("drop.out_instr", 64'(out_instr1), 64'hB000_0001);
    check("drop.out_valid", 64'(out_valid1), 64'd1);
    check("present.out_squash", 64'(out_squash0), 64'd1);
    check("present.out_valid", 64'(out_valid0), 64'd1);
    idle(1'b1, 1'b0);
    #2;
    check("present.next_instr", 64'(out_instr0), 64'hB000_0001);

    // Flush beats a concurrent push.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push_w(32'hE000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0, 1'b0);
    #2;
    check("flush.count", 64'(count0), 64'd0);
    check("flush.out_valid", 64'(out_valid0), 64'd0);

    // Reset mid-stream, then a push shows up one cycle later.
    for (int i = 0; i < 2; i++) push_w(32'hF000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #2;
    check("rst.count", 64'(count0), 64'd0);
    check("rst.out_instr", 64'(out_instr0), 64'(NOP_W));
    check("rst.in_ready", 64'(in_ready0), 64'd1);
    push_w(32'h1234_5678, 1'b0, 1'b0, 1'b1);
    #2;
    check("rst.push_latency", 64'(out_instr0), 64'h1234_5678);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      automatic logic eref = epoch_ref;
      if ($urandom_range(7) == 0) eref = ~eref;
      step(($urandom_range(63) == 0), ($urandom_range(31) == 0), ($urandom_range(1) == 1),
           $urandom(), ($urandom_range(3) != 0) ? eref : ~eref, eref, ($urandom_range(9) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
